load_store_unit: RTL
====================

Name: load_store_unit

Overview:
Initiator side of the data-memory interface. Accepts load/store requests from the CPU datapath over a valid/ready handshake and drives the word-addressed data memory's address, write strobe, read strobe and write data. Returns formatted load data or store completion over a valid/ready response channel. Adds byte/halfword access, sign/zero extension, read-modify-write for sub-word stores, and alignment checking on top of the word-only memory.

Parameters:
ADDR_W, 7, word-address width driven to memory; request byte address is ADDR_W+2 bits

Ports:
clock  in  1  system clock; all state updates on posedge
reset_n  in  1  synchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  LSU can accept; high only in IDLE
req_write  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
req_signed  in  1  loads: 1 sign-extend, 0 zero-extend
req_addr  in  ADDR_W+2  byte address
req_wdata  in  32  store data, LSB-aligned
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts response
resp_rdata  out  32  formatted load data; 0 for stores and errors
resp_err  out  1  misaligned or reserved-size request
mem_address  out  ADDR_W  word address = req_addr[ADDR_W+1:2]
mem_write  out  1  memory write strobe; memory writes on posedge
mem_read  out  1  memory read strobe; memory updates read data on negedge
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data

Behaviour:
- Reset (reset_n low at posedge): state IDLE. resp_valid, resp_err, mem_write, mem_read = 0. resp_rdata, mem_wdata, mem_address = 0. Latched request cleared.
- req_ready = (state==IDLE) && reset_n. Combinational.
- All other outputs are registered.
- Handshake: a request is accepted on a posedge with req_valid && req_ready. All request fields are latched at that edge.
- Response handshake: response completes on a posedge with resp_valid && resp_ready. resp_valid, resp_rdata and resp_err are held stable until then.
- States: IDLE, RD, WR, RESP.
- Transitions from IDLE on accept:
  - Error: size 11, or half with addr[0]=1, or word with addr[1:0]!=0. Go to RESP with resp_err=1, resp_rdata=0. No memory strobes.
  - Load: go to RD.
  - Word store: go to WR.
  - Byte/half store: go to RD, then WR (read-modify-write).
- RD: mem_read=1 for exactly one cycle, mem_address stable. Memory data is valid by the end of the cycle and is sampled at the posedge leaving RD.
  - Load: resp_rdata = formatted data, go to RESP.
  - Sub-word store: merged word is latched into mem_wdata, go to WR.
- WR: mem_write=1 for exactly one cycle. Memory commits at the posedge leaving WR. Go to RESP with resp_rdata=0, resp_err=0.
- RESP: resp_valid=1. On resp_ready go to IDLE, with resp_valid deasserting at that edge. No back-to-back overlap: the next request is accepted at the earliest one cycle after the response handshake.
- Lanes are little-endian: byte k = data[8k+7:8k]; half h = data[16h+15:16h].
- Load byte: lane addr[1:0], extended to 32 bits per req_signed. Load half: lane addr[1], extended. Load word: unchanged.
- Store merge: selected lane replaced by req_wdata[7:0] or [15:0]. Other lanes come from mem_rdata.
- mem_wdata = 0 outside WR.
- mem_address = latched word address while not IDLE; 0 in IDLE.
- Latency, in cycles from accept edge to first resp_valid cycle: load 2, word store 2, sub-word store 3, error 1.
- Reset mid-operation:
  - Returns to IDLE at that edge and the response is dropped.
  - If reset is sampled at the posedge ending WR, the memory still commits that write (mem_write was high at that edge).
  - Reset in RD: no memory effect.
- Address wrap: none. Full address range is legal; the highest word is 2^ADDR_W-1.

Optional Feature:
Macro LSU_SUBWORD_STORE_EN.
- Defined: byte/half stores use RD→WR read-modify-write as above.
- Undefined:
  - Byte/half stores that are otherwise legal are rejected as errors (resp_err=1, 1-cycle latency, no strobes).
  - The store merge logic is not built.
  - Loads of all sizes are unaffected.

Test Plan:
- Preload mem word 1 = 32'h0000_0006. Word load addr 9'h004 -> one RD cycle with mem_address=1; resp_rdata=32'h6, resp_err=0; resp_valid 2 cycles after accept.
- Preload word 2 = 32'h8070_F007. Byte load addr 9'h00B, signed -> 32'hFFFF_FF80. Same address unsigned -> 32'h0000_0080. Half load addr 9'h00A, signed -> 32'hFFFF_8070.
- With LSU_SUBWORD_STORE_EN, word 0 = 32'h0000_0005, byte store addr 9'h001 data 8'hAB -> RD then WR with mem_wdata=32'h0000_AB05; subsequent word load returns 32'h0000_AB05.
- Word store addr 9'h006 -> resp_err=1 after 1 cycle, mem_write and mem_read never asserted. Same check for half at 9'h003 and size 11.
- Load with resp_ready held low 4 cycles -> resp_valid and resp_rdata stable; req_ready low throughout; IDLE entered on the cycle after resp_ready rises.
- reset_n low during RD of a load -> next cycle IDLE, resp_valid=0, mem_read=0, req_ready=1 once reset_n is high.

Source files
------------

// File: rtl/load_store_unit.sv
// ============================================================================
// Module   : load_store_unit
// Function : Data-memory initiator: byte/half/word loads and stores over a
//            word-only memory, with sign/zero extension and alignment checks.
//            Macro LSU_SUBWORD_STORE_EN enables byte/half read-modify-write.
// Revision : 1.0
// ============================================================================
`default_nettype none

module load_store_unit #(
  parameter int ADDR_W = 7
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_write,
  output logic              mem_read,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_write;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [1:0]        r_off;
  logic [ADDR_W-1:0] r_waddr;
  logic [15:0]       r_wdata;

  logic              w_accept;
  logic              w_sub_reject;
  logic              w_req_err;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_fmt;
  logic [31:0]       w_merge;

  assign req_ready = (r_state == S_IDLE) && reset_n;
  assign w_accept  = req_valid && req_ready;

`ifdef LSU_SUBWORD_STORE_EN
  assign w_sub_reject = 1'b0;

  always_comb begin
    w_merge = mem_rdata;
    if (r_size == 2'b00)
      w_merge[{r_off, 3'b000} +: 8] = r_wdata[7:0];
    else
      w_merge[{r_off[1], 4'b0000} +: 16] = r_wdata;
  end
`else
  // Sub-word stores are rejected up front, so RD never leads to WR here.
  assign w_sub_reject = req_write && (req_size != 2'b10);
  assign w_merge      = {16'h0000, r_wdata};
`endif

  assign w_req_err = (req_size == 2'b11)
                  || ((req_size == 2'b01) && req_addr[0])
                  || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))
                  || w_sub_reject;

  always_comb begin
    w_byte = mem_rdata[{r_off, 3'b000} +: 8];
    w_half = mem_rdata[{r_off[1], 4'b0000} +: 16];
    case (r_size)
      2'b00:   w_fmt = {{24{r_signed & w_byte[7]}}, w_byte};
      2'b01:   w_fmt = {{16{r_signed & w_half[15]}}, w_half};
      default: w_fmt = mem_rdata;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_req_err)                 w_state_nxt = S_RESP;
          else if (!req_write)           w_state_nxt = S_RD;
          else if (req_size == 2'b10)    w_state_nxt = S_WR;
          else                           w_state_nxt = S_RD;
        end
      end
      S_RD:    w_state_nxt = r_write ? S_WR : S_RESP;
      S_WR:    w_state_nxt = S_RESP;
      S_RESP:  if (resp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // All outputs are registered from the next state so strobes line up with it.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_write     <= 1'b0;
      r_size      <= 2'b00;
      r_signed    <= 1'b0;
      r_off       <= 2'b00;
      r_waddr     <= '0;
      r_wdata     <= 16'h0000;
      resp_valid  <= 1'b0;
      resp_rdata  <= 32'h0;
      resp_err    <= 1'b0;
      mem_address <= '0;
      mem_write   <= 1'b0;
      mem_read    <= 1'b0;
      mem_wdata   <= 32'h0;
    end else begin
      if (w_accept) begin
        r_write  <= req_write;
        r_size   <= req_size;
        r_signed <= req_signed;
        r_off    <= req_addr[1:0];
        r_waddr  <= req_addr[ADDR_W+1:2];
        r_wdata  <= req_wdata[15:0];
      end
      mem_read   <= (w_state_nxt == S_RD);
      mem_write  <= (w_state_nxt == S_WR);
      resp_valid <= (w_state_nxt == S_RESP);

      if (w_state_nxt == S_IDLE) mem_address <= '0;
      else if (w_accept)         mem_address <= req_addr[ADDR_W+1:2];
      else                       mem_address <= r_waddr;

      if (w_state_nxt == S_WR)
        mem_wdata <= (r_state == S_IDLE) ? req_wdata : w_merge;
      else
        mem_wdata <= 32'h0;

      if (w_state_nxt == S_RESP) begin
        if (r_state != S_RESP) begin
          resp_err   <= (r_state == S_IDLE);
          resp_rdata <= ((r_state == S_RD) && !r_write) ? w_fmt : 32'h0;
        end
      end else begin
        resp_err   <= 1'b0;
        resp_rdata <= 32'h0;
      end
    end
  end

endmodule

`default_nettype wire
